// File: rtl/uart_tx_if.sv
`default_nettype none
// =============================================================================
// uart_tx_if : valid/ready word handshake between a producer and uart_tx
// Rev 1.0
// =============================================================================
interface uart_tx_if;
  logic [7:0] i_tx_data;
  logic       i_tx_valid;
  logic       o_tx_ready;
  logic       o_tx_busy;

  modport master (
    output i_tx_data,
    output i_tx_valid,
    input  o_tx_ready,
    input  o_tx_busy
  );

  modport slave (
    input  i_tx_data,
    input  i_tx_valid,
    output o_tx_ready,
    output o_tx_busy
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// =============================================================================
// uart_tx : LSB-first UART frame serialiser clocked by an external baud square
//           wave; optional parity bit when UART_TX_PARITY_EN is defined.
// Rev 1.0
// =============================================================================
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  wire logic sys_clk,
  input  wire logic sys_reset_n,
  input  wire logic i_uart_clk,
  uart_tx_if.slave  tx,
  output logic      o_uart_txd
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

`ifdef UART_TX_PARITY_EN
  localparam logic [7:0] DATA_MASK = 8'((9'd1 << DATA_BITS) - 9'd1);
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
    S_STOP   = 3'd4,
    S_PARITY = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_START = 3'd2,
    S_DATA  = 3'd3,
    S_STOP  = 3'd4
  } state_t;
`endif

  state_t     state_q, state_d;
  logic       clk_d_q;
  logic [7:0] shreg_q, shreg_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic       stop_q, stop_d;
  logic       buf_q, buf_d;
  logic       txd_q, txd_d;
`ifdef UART_TX_PARITY_EN
  logic       par_q, par_d;
`else
  logic       unused_parity_odd;
  assign unused_parity_odd = (PARITY_ODD != 0);
`endif

  logic tick;
  logic last_stop;
  logic ready;
  logic accept;

  // Baud clock is already sys_clk-synchronous, so one register gives a clean edge.
  assign tick      = i_uart_clk & ~clk_d_q;
  assign last_stop = (STOP_BITS == 1) || stop_q;
  assign ready     = (state_q == S_IDLE) ||
                     ((state_q == S_STOP) && last_stop && !buf_q);
  assign accept    = tx.i_tx_valid & ready;

  assign tx.o_tx_ready = ready;
  assign tx.o_tx_busy  = (state_q != S_IDLE);
  assign o_uart_txd    = txd_q;

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state_q  <= S_IDLE;
      clk_d_q  <= 1'b0;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      stop_q   <= 1'b0;
      buf_q    <= 1'b0;
      txd_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      clk_d_q  <= i_uart_clk;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      stop_q   <= stop_d;
      buf_q    <= buf_d;
      txd_q    <= txd_d;
`ifdef UART_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  // txd_d always carries the level of the bit that starts on this tick.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    stop_d   = stop_q;
    buf_d    = buf_q;
    txd_d    = txd_q;
`ifdef UART_TX_PARITY_EN
    par_d    = par_q;
    if (accept) par_d = (^(tx.i_tx_data & DATA_MASK)) ^ (PARITY_ODD != 0);
`endif
    if (accept) shreg_d = tx.i_tx_data;

    case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (accept) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (tick) begin
          state_d = S_START;
          txd_d   = 1'b0;
        end
      end
      S_START: begin
        if (tick) begin
          state_d  = S_DATA;
          txd_d    = shreg_q[0];
          bitcnt_d = 3'd0;
        end
      end
      S_DATA: begin
        if (tick) begin
          if (bitcnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            txd_d   = par_q;
`else
            state_d = S_STOP;
            txd_d   = 1'b1;
            stop_d  = 1'b0;
`endif
          end else begin
            shreg_d  = shreg_q >> 1;
            txd_d    = shreg_q[1];
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          state_d = S_STOP;
          txd_d   = 1'b1;
          stop_d  = 1'b0;
        end
      end
`endif
      S_STOP: begin
        if (accept) buf_d = 1'b1;
        if (tick) begin
          if (!last_stop) begin
            stop_d = 1'b1;
          end else if (buf_q || accept) begin
            state_d = S_START;
            txd_d   = 1'b0;
            buf_d   = 1'b0;
          end else begin
            state_d = S_IDLE;
            txd_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire
